// File: rtl/pulse_train_gen.sv
// pulse_train_gen: generates a train of pulse_count pulses. Each pulse holds the
// active level for max(high_cycles,1) cycles and is followed by max(low_cycles,1)
// idle cycles. Configuration is latched when a train starts. All outputs are
// registered.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; signal_out at SIGNAL_INIT
// ACTIVE | driving the active level for the current pulse
// GAP    | idle-level gap after a pulse; decides repeat or finish
module pulse_train_gen #(
    parameter int   COUNTER_WIDTH = 16,
    parameter int   PERIOD_WIDTH  = 16,
    parameter logic SIGNAL_INIT   = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [COUNTER_WIDTH-1:0] pulse_count,
    input  logic [PERIOD_WIDTH-1:0]  high_cycles,
    input  logic [PERIOD_WIDTH-1:0]  low_cycles,
    output logic                     signal_out,
    output logic                     busy,
    output logic                     done,
    output logic [COUNTER_WIDTH-1:0] pulses_sent
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    localparam logic [PERIOD_WIDTH-1:0]  P_ONE = PERIOD_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] C_ONE = COUNTER_WIDTH'(1);

    state_t                   state;
    logic [COUNTER_WIDTH-1:0] count_q;
    logic [PERIOD_WIDTH-1:0]  high_q;
    logic [PERIOD_WIDTH-1:0]  low_q;
    logic [PERIOD_WIDTH-1:0]  phase_cnt;

    // Phase timers count down to zero, so the load value is length-1. A
    // programmed length of zero is treated as one cycle, which also keeps the
    // down-counter from ever wrapping.
    function automatic logic [PERIOD_WIDTH-1:0] phase_load(input logic [PERIOD_WIDTH-1:0] len);
        return (len == '0) ? '0 : len - P_ONE;
    endfunction

    // Sequencer: state, phase timer, pulse counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            count_q     <= '0;
            high_q      <= '0;
            low_q       <= '0;
            phase_cnt   <= '0;
            signal_out  <= SIGNAL_INIT;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulses_sent <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        count_q     <= pulse_count;
                        high_q      <= high_cycles;
                        low_q       <= low_cycles;
                        if (pulse_count == '0) begin
                            // Empty train: finish immediately without any pulse.
                            pulses_sent <= '0;
                            done        <= 1'b1;
                        end else begin
                            state       <= ACTIVE;
                            signal_out  <= ~SIGNAL_INIT;
                            busy        <= 1'b1;
                            pulses_sent <= C_ONE;
                            phase_cnt   <= phase_load(high_cycles);
                        end
                    end
                end
                ACTIVE: begin
                    if (abort) begin
                        state      <= IDLE;
                        signal_out <= SIGNAL_INIT;
                        busy       <= 1'b0;
                    end else if (phase_cnt == '0) begin
                        state      <= GAP;
                        signal_out <= SIGNAL_INIT;
                        phase_cnt  <= phase_load(low_q);
                    end else begin
                        phase_cnt <= phase_cnt - P_ONE;
                    end
                end
                GAP: begin
                    if (abort) begin
                        state      <= IDLE;
                        signal_out <= SIGNAL_INIT;
                        busy       <= 1'b0;
                    end else if (phase_cnt == '0) begin
                        // pulses_sent never exceeds count_q, so the increment
                        // cannot overflow even at the maximum pulse count.
                        if (pulses_sent < count_q) begin
                            state       <= ACTIVE;
                            signal_out  <= ~SIGNAL_INIT;
                            pulses_sent <= pulses_sent + C_ONE;
                            phase_cnt   <= phase_load(high_q);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - P_ONE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    signal_out <= SIGNAL_INIT;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
